ucsbece154b_branch_predictor: RTL and testbench

Gshare direction predictor with a direct-mapped branch target buffer (BTB) for the fetch stage of the pipelined RISC-V core. It looks up the fetch PC combinationally and supplies a predicted-taken flag and target, which the fetch PC mux uses ahead of PC+4. It is trained from the execute stage, which reports resolved outcomes. On a misprediction it restores the global history register (GHR) from the checkpoint carried down the pipe.

---
 rtl/ucsbece154b_branch_predictor_if.sv | 36 +++
 rtl/ucsbece154b_branch_predictor.sv | 101 ++++++++++
 tb/tb_ucsbece154b_branch_predictor.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ucsbece154b_branch_predictor_if.sv
// Fetch-lookup and execute-training signals between the pipeline and the branch predictor.
// The pipeline holds the master modport; the predictor holds the slave modport.
interface ucsbece154b_branch_predictor_if #(
  parameter int NUM_GHR_BITS = 5
);
  logic [31:0]             pcF_i;
  logic                    advanceF_i;
  logic                    predTakenF_o;
  logic [31:0]             btbTargetF_o;
  logic [NUM_GHR_BITS-1:0] phtIndexF_o;
  logic [NUM_GHR_BITS-1:0] ghrF_o;

  logic                    validE_i;
  logic [31:0]             pcE_i;
  logic                    isBranchE_i;
  logic                    isJumpE_i;
  logic                    takenE_i;
  logic [31:0]             targetE_i;
  logic [NUM_GHR_BITS-1:0] phtIndexE_i;
  logic [NUM_GHR_BITS-1:0] ghrE_i;
  logic                    mispredictE_i;

  modport master (
    output pcF_i, advanceF_i,
    output validE_i, pcE_i, isBranchE_i, isJumpE_i, takenE_i, targetE_i,
    output phtIndexE_i, ghrE_i, mispredictE_i,
    input  predTakenF_o, btbTargetF_o, phtIndexF_o, ghrF_o
  );

  modport slave (
    input  pcF_i, advanceF_i,
    input  validE_i, pcE_i, isBranchE_i, isJumpE_i, takenE_i, targetE_i,
    input  phtIndexE_i, ghrE_i, mispredictE_i,
    output predTakenF_o, btbTargetF_o, phtIndexF_o, ghrF_o
  );
endinterface

// File: rtl/ucsbece154b_branch_predictor.sv
// Direction predictor plus direct-mapped BTB for the fetch stage, trained from execute.
// Define BPRED_GSHARE_EN for gshare indexing with a global history register; otherwise bimodal.
module ucsbece154b_branch_predictor #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5
) (
  input logic                           clk,
  input logic                           reset_i,
  ucsbece154b_branch_predictor_if.slave bp
);

  localparam int IDX         = $clog2(NUM_BTB_ENTRIES);
  localparam int TAG_W       = 30 - IDX;
  localparam int PHT_ENTRIES = 1 << NUM_GHR_BITS;

  logic                    btbValid  [NUM_BTB_ENTRIES];
  logic                    btbJump   [NUM_BTB_ENTRIES];
  logic [TAG_W-1:0]        btbTag    [NUM_BTB_ENTRIES];
  logic [31:0]             btbTarget [NUM_BTB_ENTRIES];
  logic [1:0]              pht       [PHT_ENTRIES];
  logic [NUM_GHR_BITS-1:0] ghr;

  logic [IDX-1:0]          idxF, idxE;
  logic                    hitF, jumpF, phtTakenF;
  logic [NUM_GHR_BITS-1:0] phtIndexF;
  logic                    trainE, trainBranchE;
  logic [1:0]              phtNextE;

  // Fetch lookup; ghr is tied to zero in the bimodal build, which reduces the XOR to pc bits.
  assign idxF      = bp.pcF_i[IDX+1:2];
  assign hitF      = btbValid[idxF] && (btbTag[idxF] == bp.pcF_i[31:IDX+2]);
  assign jumpF     = btbJump[idxF];
  assign phtIndexF = bp.pcF_i[NUM_GHR_BITS+1:2] ^ ghr;
  assign phtTakenF = pht[phtIndexF][1];

  assign bp.predTakenF_o = hitF && (jumpF || phtTakenF);
  assign bp.btbTargetF_o = hitF ? btbTarget[idxF] : 32'h0;
  assign bp.phtIndexF_o  = phtIndexF;
  assign bp.ghrF_o       = ghr;

  assign idxE         = bp.pcE_i[IDX+1:2];
  assign trainE       = bp.validE_i && (bp.isBranchE_i || bp.isJumpE_i);
  assign trainBranchE = bp.validE_i && bp.isBranchE_i;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    phtNextE = pht[bp.phtIndexE_i];
    if (bp.takenE_i) begin
      if (phtNextE != 2'b11) phtNextE = phtNextE + 2'b01;
    end else begin
      if (phtNextE != 2'b00) phtNextE = phtNextE - 2'b01;
    end
  end

  // NOTE: state registers use <= so every always_ff reads pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= 2'b01;
    end else if (trainBranchE) begin
      pht[bp.phtIndexE_i] <= phtNextE;
    end
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < NUM_BTB_ENTRIES; i++) btbValid[i] <= 1'b0;
    end else if (trainE && bp.takenE_i) begin
      btbValid[idxE] <= 1'b1;
    end
  end

  // NOTE: only the valid bits need reset; tag/target/jump are never read while their entry is invalid.
  always_ff @(posedge clk) begin
    if (trainE && bp.takenE_i) begin
      btbJump[idxE]   <= bp.isJumpE_i;
      btbTag[idxE]    <= bp.pcE_i[31:IDX+2];
      btbTarget[idxE] <= bp.targetE_i;
    end
  end

`ifdef BPRED_GSHARE_EN
  // An execute restore overrides the speculative shift issued in the same cycle.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      ghr <= '0;
    end else if (trainE && bp.mispredictE_i) begin
      ghr <= bp.isBranchE_i ? {bp.ghrE_i[NUM_GHR_BITS-2:0], bp.takenE_i} : bp.ghrE_i;
    end else if (bp.advanceF_i && hitF && !jumpF) begin
      ghr <= {ghr[NUM_GHR_BITS-2:0], phtTakenF};
    end
  end
`else
  logic unusedBimodal;
  assign ghr           = '0;
  assign unusedBimodal = ^{bp.advanceF_i, bp.ghrE_i, bp.mispredictE_i};
`endif

  logic unusedPcBits;
  assign unusedPcBits = ^{bp.pcF_i[1:0], bp.pcE_i[1:0]};

endmodule

// File: tb/tb_ucsbece154b_branch_predictor.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized traffic,
// all compared each cycle against an associative-array/integer model of the predictor.
module tb_ucsbece154b_branch_predictor;

  localparam int N    = 5;
  localparam int E    = 32;
  localparam int IDXW = 5;
  localparam int P    = 1 << N;
`ifdef BPRED_GSHARE_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  ucsbece154b_branch_predictor_if #(.NUM_GHR_BITS(N)) bp ();

  ucsbece154b_branch_predictor #(
    .NUM_BTB_ENTRIES(E),
    .NUM_GHR_BITS   (N)
  ) dut (
    .clk    (clk),
    .reset_i(reset_i),
    .bp     (bp)
  );

  typedef struct {
    int unsigned tag;
    logic [31:0] target;
    bit          jump;
  } btb_t;

  btb_t btbMap [int unsigned];
  int   phtCnt [P];
  int   ghrM;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    btbMap.delete();
    for (int i = 0; i < P; i++) phtCnt[i] = 1;
    ghrM = 0;
  endtask

  // Fetch-side view of the model for the current inputs.
  task automatic lookup(output bit hit, output bit jmp, output logic [31:0] tgt, output int pidx);
    int unsigned pc, idx;
    pc   = bp.pcF_i;
    idx  = (pc >> 2) % E;
    hit  = 1'b0;
    jmp  = 1'b0;
    tgt  = 32'h0;
    if (btbMap.exists(idx)) begin
      if (btbMap[idx].tag == (pc >> (IDXW + 2))) begin
        hit = 1'b1;
        jmp = btbMap[idx].jump;
        tgt = btbMap[idx].target;
      end
    end
    pidx = int'(((pc >> 2) % P)) ^ ghrM;
  endtask

  task automatic compareAll();
    bit hit, jmp;
    logic [31:0] tgt;
    int pidx;
    lookup(hit, jmp, tgt, pidx);
    check("predTaken", 32'(bp.predTakenF_o), 32'(hit && (jmp || phtCnt[pidx] >= 2)));
    check("btbTarget", bp.btbTargetF_o, tgt);
    check("phtIndex", 32'(bp.phtIndexF_o), 32'(pidx));
    check("ghr", 32'(bp.ghrF_o), 32'(ghrM));
  endtask

  task automatic modelStep();
    bit hit, jmp;
    logic [31:0] tgt;
    int pidx, nextGhr, c;
    int unsigned pcE, idxE;
    if (!reset_i) begin
      modelReset();
      return;
    end
    lookup(hit, jmp, tgt, pidx);
    nextGhr = ghrM;
    if (GS && bp.advanceF_i && hit && !jmp)
      nextGhr = (ghrM * 2 + int'(phtCnt[pidx] >= 2)) % P;
    if (bp.validE_i && (bp.isBranchE_i || bp.isJumpE_i)) begin
      pcE  = bp.pcE_i;
      idxE = (pcE >> 2) % E;
      if (GS && bp.mispredictE_i)
        nextGhr = bp.isBranchE_i ? (int'(bp.ghrE_i) * 2 + int'(bp.takenE_i)) % P : int'(bp.ghrE_i);
      if (bp.isBranchE_i) begin
        c = phtCnt[bp.phtIndexE_i];
        phtCnt[bp.phtIndexE_i] = bp.takenE_i ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
      end
      if (bp.takenE_i)
        btbMap[idxE] = '{tag: pcE >> (IDXW + 2), target: bp.targetE_i, jump: bp.isJumpE_i};
    end
    ghrM = nextGhr;
  endtask

  // Called with inputs already driven just after a rising edge.
  task automatic step();
    #2;
    compareAll();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic setF(input logic [31:0] pc, input logic adv);
    bp.pcF_i      = pc;
    bp.advanceF_i = adv;
  endtask

  task automatic setE(input logic v, input logic [31:0] pc, input logic br, input logic jp,
                      input logic tk, input logic [31:0] tgt, input logic [N-1:0] pi,
                      input logic [N-1:0] gh, input logic mp);
    bp.validE_i      = v;
    bp.pcE_i         = pc;
    bp.isBranchE_i   = br;
    bp.isJumpE_i     = jp;
    bp.takenE_i      = tk;
    bp.targetE_i     = tgt;
    bp.phtIndexE_i   = pi;
    bp.ghrE_i        = gh;
    bp.mispredictE_i = mp;
  endtask

  task automatic idleE();
    setE(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, '0, '0, 1'b0);
  endtask

  initial begin
    reset_i = 1'b0;
    setF(32'h0001_0000, 1'b0);
    idleE();
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b1;

    // Reset state
    #2;
    check("rst_pred", 32'(bp.predTakenF_o), 32'd0);
    check("rst_target", bp.btbTargetF_o, 32'h0);
    check("rst_ghr", 32'(bp.ghrF_o), 32'd0);
    check("rst_phtIndex", 32'(bp.phtIndexF_o), 32'd0);
    step();

    // First taken branch, mispredicted, allocates BTB entry 2
    setE(1'b1, 32'h0001_0008, 1'b1, 1'b0, 1'b1, 32'h0001_0020, 5'd2, 5'd0, 1'b1);
    step();
    idleE();
    setF(32'h0001_0008, 1'b0);
    #2;
    check("hit_target", bp.btbTargetF_o, 32'h0001_0020);
    check("hit_ghr", 32'(bp.ghrF_o), GS ? 32'd1 : 32'd0);
    check("hit_phtIndex", 32'(bp.phtIndexF_o), GS ? 32'd3 : 32'd2);
    check("hit_pred", 32'(bp.predTakenF_o), GS ? 32'd0 : 32'd1);
    check("model_pht2_a", 32'(phtCnt[2]), 32'd2);
    step();

    // Saturate at 3, then one not-taken drops it to 2
    setE(1'b1, 32'h0001_0008, 1'b1, 1'b0, 1'b1, 32'h0001_0020, 5'd2, 5'd0, 1'b0);
    repeat (3) step();
    check("model_pht2_sat", 32'(phtCnt[2]), 32'd3);
    setE(1'b1, 32'h0001_0008, 1'b1, 1'b0, 1'b0, 32'h0001_000c, 5'd2, 5'd0, 1'b0);
    step();
    check("model_pht2_b", 32'(phtCnt[2]), 32'd2);

    // jal trained with mispredict restores history to its checkpoint (0)
    setE(1'b1, 32'h0001_0040, 1'b0, 1'b1, 1'b1, 32'h0001_0100, 5'd0, 5'd0, 1'b1);
    step();
    idleE();
    #2;
    check("branch_pred_taken", 32'(bp.predTakenF_o), 32'd1);
    check("ghr_after_jal", 32'(bp.ghrF_o), 32'd0);
    step();
    setF(32'h0001_0040, 1'b1);
    #2;
    check("jal_pred", 32'(bp.predTakenF_o), 32'd1);
    check("jal_target", bp.btbTargetF_o, 32'h0001_0100);
    step();
    setF(32'h0001_0044, 1'b0);
    #2;
    check("jal_no_shift", 32'(bp.ghrF_o), 32'd0);
    step();

    // Speculative shift and restore in the same cycle: restore wins
    setF(32'h0001_0008, 1'b1);
    setE(1'b1, 32'h0001_0080, 1'b1, 1'b0, 1'b0, 32'h0, 5'd7, 5'b10110, 1'b1);
    step();
    idleE();
    setF(32'h0001_0000, 1'b0);
    #2;
    check("restore_wins", 32'(bp.ghrF_o), GS ? 32'b01100 : 32'd0);
    step();

    // Asynchronous reset mid-cycle
    setF(32'h0001_0040, 1'b0);
    #2;
    check("pre_reset_pred", 32'(bp.predTakenF_o), 32'd1);
    reset_i = 1'b0;
    modelReset();
    #1;
    check("async_reset_pred", 32'(bp.predTakenF_o), 32'd0);
    compareAll();
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    #2;
    check("post_reset_target", bp.btbTargetF_o, 32'h0);
    step();

    // Randomized traffic over a small PC window with an aliasing tag to force replacement
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pcf, pce;
      logic br, jp;
      pcf = 32'h0001_0000 + ($urandom_range(0, 63) << 2) + (($urandom_range(0, 3) == 0) ? 32'h0010_0000 : 32'h0);
      pce = 32'h0001_0000 + ($urandom_range(0, 63) << 2) + (($urandom_range(0, 3) == 0) ? 32'h0010_0000 : 32'h0);
      br  = $urandom_range(0, 2) != 0;
      jp  = !br && ($urandom_range(0, 1) == 1);
      setF(pcf, 1'($urandom_range(0, 1)));
      setE(1'($urandom_range(0, 4) != 0), pce, br, jp, jp | 1'($urandom_range(0, 1)),
           {$urandom_range(0, 32'h3fff_ffff), 2'b00}, N'($urandom_range(0, P - 1)),
           N'($urandom_range(0, P - 1)), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 15) == 0) begin
        bp.mispredictE_i = 1'b1;
        bp.isBranchE_i   = 1'b0;
        bp.isJumpE_i     = 1'b0;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
